// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Combines hazard, branch, memory stalls and HALT into per-stage enables,
// an IF/ID flush and an ID/EX bubble; runs the halt drain and keeps
// saturating stall/flush counters plus a sticky hazard-timeout flag.
module pipe_ctrl #(
  parameter int CNT_W   = 16,
  parameter int MAX_HAZ = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sendNOP,
  input  logic             branch_taken,
  input  logic             imem_stall,
  input  logic             dmem_stall,
  input  logic             halt_id,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             halted,
  output logic             haz_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // haz_run only needs to reach MAX_HAZ+1, where it parks.
  localparam int              HR_W    = $clog2(MAX_HAZ + 2);
  localparam logic [HR_W-1:0] HR_MAX  = HR_W'(MAX_HAZ + 1);
  localparam logic [HR_W-1:0] HR_TRIP = HR_W'(MAX_HAZ);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t            r_state;
  logic [HR_W-1:0]   r_haz_run;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic              r_haz_err;

  logic w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en;
  logic w_ifid_flush, w_idex_bubble;

  // Mealy control decode: enables/flush/bubble from state and this cycle's inputs.
  always_comb begin
    w_pc_en       = 1'b0;
    w_ifid_en     = 1'b0;
    w_idex_en     = 1'b0;
    w_exmem_en    = 1'b0;
    w_memwb_en    = 1'b0;
    w_ifid_flush  = 1'b0;
    w_idex_bubble = 1'b0;
    if (rst) begin
      w_pc_en = 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (dmem_stall) begin
            w_pc_en = 1'b0;
          end else if (branch_taken) begin
            // Squash the ID instruction; hazard and halt in ID are moot.
            {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = 5'b11111;
            w_ifid_flush  = 1'b1;
            w_idex_bubble = 1'b1;
          end else if (!sendNOP) begin
            {w_idex_en, w_exmem_en, w_memwb_en} = 3'b111;
            w_idex_bubble = 1'b1;
          end else if (imem_stall) begin
            {w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = 4'b1111;
            w_ifid_flush = 1'b1;
          end else begin
            // Normal advance, including the cycle a HALT leaves ID.
            {w_pc_en, w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = 5'b11111;
          end
        end
        ST_DRAIN: begin
          if (dmem_stall) begin
            w_pc_en = 1'b0;
          end else begin
            {w_ifid_en, w_idex_en, w_exmem_en, w_memwb_en} = 4'b1111;
            w_ifid_flush = 1'b1;
          end
        end
        ST_HALTED: w_pc_en = 1'b0;
        default:   w_pc_en = 1'b0;
      endcase
    end
  end

  assign pc_en       = w_pc_en;
  assign ifid_en     = w_ifid_en;
  assign idex_en     = w_idex_en;
  assign exmem_en    = w_exmem_en;
  assign memwb_en    = w_memwb_en;
  assign ifid_flush  = w_ifid_flush;
  assign idex_bubble = w_idex_bubble;
  assign halted      = (r_state == ST_HALTED);
  assign haz_err     = r_haz_err;
  assign stall_cnt   = r_stall_cnt;
  assign flush_cnt   = r_flush_cnt;

  // Sequencer state, hazard run length, sticky error and saturating counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_haz_run   <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
      r_haz_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (dmem_stall) begin
            r_haz_run <= r_haz_run;
          end else if (branch_taken) begin
            r_haz_run <= '0;
            if (r_flush_cnt != CNT_MAX) r_flush_cnt <= r_flush_cnt + 1'b1;
          end else if (!sendNOP) begin
            if (r_stall_cnt != CNT_MAX) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (r_haz_run != HR_MAX) r_haz_run <= r_haz_run + 1'b1;
            // This stall makes the run MAX_HAZ+1 long.
            if (r_haz_run >= HR_TRIP) r_haz_err <= 1'b1;
          end else begin
            r_haz_run <= '0;
            if (!imem_stall && halt_id) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!dmem_stall) begin
            r_haz_run <= '0;
            if (halt_wb) r_state <= ST_HALTED;
          end
        end
        ST_HALTED: r_haz_run <= '0;
        default:   r_state   <= ST_RUN;
      endcase
    end
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It combines the decode-stage hazard result (`sendNOP`), the EX-stage branch resolution, instruction/data memory stalls and HALT into per-stage register enables, an IF/ID flush and an ID/EX bubble. It also runs the halt-drain sequence and keeps saturating performance counters. It sits beside the decode hazard comparator and drives every pipeline register's write/flush controls.

## Interface
- `CNT_W`, 16: width of performance counters.
- `MAX_HAZ`, 3: consecutive hazard-stall cycles allowed before `haz_err` is raised.

- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset; asynchronous, active-high.
- `sendNOP` in 1: low when the ID instruction has a RAW hazard against EX/MEM/WB.
- `branch_taken` in 1: EX-stage branch/jump resolved taken this cycle.
- `imem_stall` in 1: instruction memory not ready this cycle.
- `dmem_stall` in 1: data memory busy; freezes the whole pipe.
- `halt_id` in 1: HALT decoded in ID.
- `halt_wb` in 1: HALT has reached WB.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en` out 1 each: pipeline register write enables.
- `ifid_flush` out 1: load NOP (16'h0800) into IF/ID.
- `idex_bubble` out 1: load a NOP (all writes/mem disabled) into ID/EX.
- `halted` out 1: core stopped.
- `haz_err` out 1: sticky; hazard stall exceeded `MAX_HAZ`.
- `stall_cnt` out `CNT_W`: hazard-stall cycles, saturating.
- `flush_cnt` out `CNT_W`: taken-branch flushes, saturating.

## Operation
- States: RUN, DRAIN, HALTED. The outputs are Mealy: combinational from state and inputs.
- In RUN, the per-cycle condition is evaluated in this priority order:
  1. `dmem_stall`: all enables 0, no flush or bubble, counters hold. A held `branch_taken` or hazard is re-evaluated after the stall releases.
  2. `branch_taken`:
     - all enables 1, `ifid_flush`=1, `idex_bubble`=1.
     - `sendNOP` and `halt_id` are ignored because the ID instruction is squashed.
     - `flush_cnt`++.
  3. `sendNOP`=0:
     - `pc_en`=0, `ifid_en`=0, `idex_bubble`=1, `idex_en`/`exmem_en`/`memwb_en`=1.
     - `stall_cnt`++, `haz_run`++.
     - When `haz_run` reaches `MAX_HAZ`+1, set `haz_err`.
  4. `imem_stall`: `pc_en`=0, `ifid_flush`=1, other enables 1.
  5. `halt_id`: normal advance this cycle, then go to DRAIN.
  6. Otherwise: all enables 1, no flush or bubble.
- `haz_run` clears on any cycle not in case 3, except that case 1 holds it.
- DRAIN:
  - `pc_en`=0, `ifid_flush`=1, downstream enables 1; `dmem_stall` still freezes everything.
  - `halt_wb`=1 moves the block to HALTED. A branch cannot arrive because the older instructions were already resolved.
- HALTED: all enables 0, `halted`=1; leaves only on `rst`.
- Counters stick at 2^`CNT_W`−1. `haz_err` clears only on reset.

## Timing
- Reset (async, effective immediately):
  - state=RUN, `haz_run`=0, counters=0, `haz_err`=0, `halted`=0.
  - While `rst`=1, all enables, `ifid_flush` and `idex_bubble` are forced 0.
- Enables, flush and bubble respond in the same cycle as their inputs (zero latency); pipeline registers sample them at the next edge.
- State, counters and `haz_err` update at the rising edge following the causing cycle.
- Reset asserted mid-DRAIN or mid-stall aborts the sequence and returns to RUN with a clean state.
- Branch and hazard in the same cycle: branch wins, no stall is counted, and `haz_run` clears.

## Test plan
- Single RAW hazard:
  - Stimulus: `sendNOP`=0 for 2 cycles, then 1.
  - Response: `pc_en`/`ifid_en` low 2 cycles, `idex_bubble` high 2 cycles, `stall_cnt`=2, `haz_err`=0.
- Taken branch coinciding with a hazard:
  - Stimulus: `branch_taken`=1 and `sendNOP`=0 in the same cycle.
  - Response: all enables 1, flush+bubble 1, `flush_cnt`=1, `stall_cnt`=0.
- `dmem_stall` over a branch:
  - Stimulus: 3-cycle `dmem_stall` with `branch_taken` held.
  - Response: all enables 0 for 3 cycles, then flush exactly once, `flush_cnt`=1.
- Hazard timeout:
  - Stimulus: `MAX_HAZ`=3, `sendNOP`=0 for 4 cycles.
  - Response: `haz_err`=1 after the 4th edge and stays set after `sendNOP`=1.
- Halt drain:
  - Stimulus: `halt_id` pulse, `halt_wb` 3 cycles later.
  - Response: `pc_en`=0 from the next cycle, then `halted`=1 and all enables 0; `rst` returns to RUN with counters 0.
- Counter saturation:
  - Stimulus: `CNT_W`=2, 5 hazard cycles with `MAX_HAZ` large.
  - Response: `stall_cnt`=3.
